id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   Decode-to-execute pipeline stage: captures a decoded instruction and its register-file operands
//   into the ID/EX register with a valid/ready handshake on both sides.
//   Detects load-use hazards and inserts bubbles. Applies branch flushes.
//   Optionally bypasses the same-cycle writeback value around the register file.
//   Sits between the decoder/register file (upstream) and the execute stage (downstream).
// PARAMETERS
//   XLEN    32  datapath width (pc, imm, operands)
//   CTRL_W  16  width of packed control bundle (cpu_pkg::ctrl_t); bit MEM_READ_BIT marks a load
// PORTS
//   clk            in   1       rising-edge clock
//   rst            in   1       reset; fixed as synchronous and active-high
//   in_valid       in   1       upstream holds a decoded instruction
//   in_ready       out  1       stage accepts upstream this cycle
//   in_pc          in   XLEN    instruction pc
//   in_imm         in   XLEN    decoded immediate
//   in_ctrl        in   CTRL_W  control bundle
//   in_rs1_addr    in   5       source 1 index; in_rs1_used in 1 = source 1 read by instr
//   in_rs2_addr    in   5       source 2 index; in_rs2_used in 1 = source 2 read by instr
//   in_rd_addr     in   5       destination index
//   rs1_data       in   XLEN    register-file read port 1 (x0 reads 0)
//   rs2_data       in   XLEN    register-file read port 2
//   wb_reg_write   in   1       writeback writes register file this cycle
//   wb_addr        in   5       writeback destination
//   wb_data        in   XLEN    writeback value
//   flush          in   1       branch/jump redirect from execute
//   out_valid      out  1       ID/EX register holds a valid instruction
//   out_ready      in   1       execute consumes this cycle
//   out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN   registered payload
//   out_ctrl       out  CTRL_W  registered control
//   out_rd_addr    out  5       registered destination
// BEHAVIOUR
//   - Reset: out_valid=0; all out_* payload=0. in_ready=0 during rst.
//   - A transfer happens when valid&ready on a side. Output payload is registered. Latency is 1 cycle in to out.
//   - Stall (hold): out_valid=1 and out_ready=0. The payload stays stable; in_ready=0.
//   - load_use = out_valid & out_ctrl[MEM_READ_BIT] & out_rd_addr!=0 &
//     ((in_rs1_used & in_rs1_addr==out_rd_addr) | (in_rs2_used & in_rs2_addr==out_rd_addr)).
//   - On load_use: in_ready=0. If out_ready=1 then out_valid<=0 next cycle (one bubble).
//     The instruction is accepted the cycle after.
//   - in_ready = !rst & !flush & !load_use & !wb_hazard & (!out_valid | out_ready).
//   - flush: highest priority after rst. out_valid<=0 next edge and in_ready=0 (input dropped).
//     Simultaneous flush+load_use: flush wins.
//   - Output register load: when in_valid&in_ready. Otherwise if out_ready: out_valid<=0.
//   - Operand values come from the register file. x0 is always 0, including when a bypass hits x0.
// CONFIGURATION
//   ID_WB_BYPASS_EN defined:
//     - out_rsN_val = (wb_reg_write & wb_addr!=0 & wb_addr==in_rsN_addr) ? wb_data : rsN_data.
//     - wb_hazard=0.
//   ID_WB_BYPASS_EN undefined:
//     - No bypass; rsN_data is used raw.
//     - wb_hazard=1 when wb_reg_write & wb_addr!=0 & a used source matches wb_addr.
//     - Result: a 1-cycle stall until the write has landed.
// STRUCTURE
//   - cpu_pkg: ctrl_t packed struct (CTRL_W bits), MEM_READ_BIT, REG_ADDR_W=5, XLEN default.
//   - Sub-module id_hazard_detect: combinational; produces load_use and wb_hazard.
//   - The ID/EX register and handshake stay in this module.
// TESTING
//   1. rst high 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_pc=0.
//      After release, in_pc=0x100 accepted; next cycle out_pc=0x100, out_valid=1.
//   2. out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0.
//      out_* stable across all 3 cycles; no upstream transfer.
//   3. EX holds load rd=x5; ID instr uses rs1=x5 -> one bubble (out_valid=0 one cycle).
//      Then the instr issues. With rd=x0 -> no bubble.
//   4. flush with in_valid=1 and load_use=1 -> out_valid=0 next cycle, input not accepted.
//   5. BYPASS_EN: wb x7<=0xDEADBEEF while ID reads rs2=x7, rs2_data=0x1 -> out_rs2_val=0xDEADBEEF.
//      wb to x0 -> no bypass.
//   6. No BYPASS_EN: same stimulus -> 1-cycle stall (in_ready=0).
//      Next cycle out_rs2_val=0xDEADBEEF from the updated rs2_data.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the decode/execute slice
// Control bundle layout: mem_read sits at bit MEM_READ_BIT of ctrl_t.
package cpu_pkg;

   localparam int XLEN         = 32;
   localparam int CTRL_W       = 16;
   localparam int REG_ADDR_W   = 5;
   localparam int MEM_READ_BIT = 1;

   typedef struct packed {
      logic [7:0] alu_op;
      logic [2:0] funct3;
      logic       jump;
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       reg_write;
   } ctrl_t;

   // A used source matching a non-x0 destination.
   function automatic logic src_hit(input logic                  used,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] dst);
      return used && (src == dst) && (dst != '0);
   endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// rtl/id_hazard_detect.sv - combinational load-use and writeback hazard detection
// With ID_WB_BYPASS_EN defined the writeback value is bypassed, so wb_hazard_o is tied low.
module id_hazard_detect
   import cpu_pkg::*;
(
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic                  rs1_used_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   input  logic                  rs2_used_i,
   input  logic                  wb_reg_write_i,
   input  logic [REG_ADDR_W-1:0] wb_addr_i,
   output logic                  load_use_o,
   output logic                  wb_hazard_o
);

   assign load_use_o = ex_valid_i && ex_mem_read_i &&
                       (src_hit(rs1_used_i, rs1_addr_i, ex_rd_addr_i) ||
                        src_hit(rs2_used_i, rs2_addr_i, ex_rd_addr_i));

`ifdef ID_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb   = ^{wb_reg_write_i, wb_addr_i};
   assign wb_hazard_o = 1'b0;
`else
   // Register file is not write-through: wait one cycle for the write to land.
   assign wb_hazard_o = wb_reg_write_i &&
                        (src_hit(rs1_used_i, rs1_addr_i, wb_addr_i) ||
                         src_hit(rs2_used_i, rs2_addr_i, wb_addr_i));
`endif

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with handshake, hazard bubbles and flush
// Optional writeback bypass enabled by defining ID_WB_BYPASS_EN.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [4:0]        in_rs1_addr,
   input  logic              in_rs1_used,
   input  logic [4:0]        in_rs2_addr,
   input  logic              in_rs2_used,
   input  logic [4:0]        in_rd_addr,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_rs1_val,
   output logic [XLEN-1:0]   out_rs2_val,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [4:0]        out_rd_addr
);

   import cpu_pkg::*;

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   pc_q, imm_q, rs1_val_q, rs2_val_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   rs1_val_d, rs2_val_d;
   logic              load_use, wb_hazard, load_en;

   id_hazard_detect u_hazard (
      .ex_valid_i     (out_valid_q),
      .ex_mem_read_i  (ctrl_q[MEM_READ_BIT]),
      .ex_rd_addr_i   (rd_q),
      .rs1_addr_i     (in_rs1_addr),
      .rs1_used_i     (in_rs1_used),
      .rs2_addr_i     (in_rs2_addr),
      .rs2_used_i     (in_rs2_used),
      .wb_reg_write_i (wb_reg_write),
      .wb_addr_i      (wb_addr),
      .load_use_o     (load_use),
      .wb_hazard_o    (wb_hazard)
   );

   assign in_ready = !rst && !flush && !load_use && !wb_hazard && (!out_valid_q || out_ready);
   assign load_en  = in_valid && in_ready;

   always_comb begin
      rs1_val_d = rs1_data;
      rs2_val_d = rs2_data;
`ifdef ID_WB_BYPASS_EN
      if (wb_reg_write && wb_addr != '0 && wb_addr == in_rs1_addr) rs1_val_d = wb_data;
      if (wb_reg_write && wb_addr != '0 && wb_addr == in_rs2_addr) rs2_val_d = wb_data;
`endif
      // x0 reads zero regardless of register file or bypass contents.
      if (in_rs1_addr == '0) rs1_val_d = '0;
      if (in_rs2_addr == '0) rs2_val_d = '0;
   end

`ifndef ID_WB_BYPASS_EN
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (load_en)   out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         rs1_val_q   <= '0;
         rs2_val_q   <= '0;
         ctrl_q      <= '0;
         rd_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (load_en) begin
            pc_q      <= in_pc;
            imm_q     <= in_imm;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            ctrl_q    <= in_ctrl;
            rd_q      <= in_rd_addr;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_pc      = pc_q;
   assign out_imm     = imm_q;
   assign out_rs1_val = rs1_val_q;
   assign out_rs2_val = rs2_val_q;
   assign out_ctrl    = ctrl_q;
   assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
// Bypass expectations follow the ID_WB_BYPASS_EN macro.
module tb_id_ex_stage;

   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready;
   logic [31:0] in_pc, in_imm;
   logic [15:0] in_ctrl;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic        in_rs1_used, in_rs2_used;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_reg_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush, out_valid, out_ready;
   logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
   logic [15:0] out_ctrl;
   logic [4:0]  out_rd_addr;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [15:0] ctrl;
      logic [4:0]  rd;
      logic [31:0] v1;
      logic [31:0] v2;
   } exp_t;

   exp_t q[$];
   exp_t cur;

   localparam logic [15:0] C_ALU  = 16'h0101;
   localparam logic [15:0] C_LOAD = 16'h0003;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
      .in_rs1_addr(in_rs1_addr), .in_rs1_used(in_rs1_used),
      .in_rs2_addr(in_rs2_addr), .in_rs2_used(in_rs2_used),
      .in_rd_addr(in_rd_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_rs1_val(out_rs1_val),
      .out_rs2_val(out_rs2_val), .out_ctrl(out_ctrl), .out_rd_addr(out_rd_addr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                        input logic [4:0] r1, input logic u1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic u2, input logic [31:0] d2,
                        input logic [4:0] rd);
      in_valid = v;  in_pc = pc;  in_imm = pc ^ 32'h5A5A_0000;  in_ctrl = ctrl;
      in_rs1_addr = r1;  in_rs1_used = u1;  rs1_data = d1;
      in_rs2_addr = r2;  in_rs2_used = u2;  rs2_data = d2;
      in_rd_addr = rd;
   endtask

   task automatic expect_ready(input logic e, input logic [31:0] v1, input logic [31:0] v2);
      exp_t x;
      #1;
      chk("in_ready", in_ready, e);
      if (e && in_valid) begin
         x.pc = in_pc;  x.imm = in_pc ^ 32'h5A5A_0000;  x.ctrl = in_ctrl;
         x.rd = in_rd_addr;  x.v1 = v1;  x.v2 = v2;
         q.push_back(x);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input logic ev, input logic fresh);
      chk("out_valid", out_valid, ev);
      if (ev) begin
         if (fresh) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) cur = q.pop_front();
         end
         chk("out_pc", out_pc, cur.pc);
         chk("out_imm", out_imm, cur.imm);
         chk("out_ctrl", out_ctrl, cur.ctrl);
         chk("out_rd_addr", out_rd_addr, cur.rd);
         chk("out_rs1_val", out_rs1_val, cur.v1);
         chk("out_rs2_val", out_rs2_val, cur.v2);
      end
   endtask

   initial begin
      rst = 1'b1;  flush = 1'b0;  out_ready = 1'b1;
      wb_reg_write = 1'b0;  wb_addr = '0;  wb_data = '0;
      cur = '0;
      drive(1'b1, 32'h100, C_ALU, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 5'd3);

      // Reset held two cycles with in_valid high.
      for (int i = 0; i < 2; i++) begin
         expect_ready(1'b0, '0, '0);
         tick();
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_pc", out_pc, 32'h0);
      end

      rst = 1'b0;
      expect_ready(1'b1, 32'h11, 32'h22);
      tick();
      check_out(1'b1, 1'b1);

      // Downstream stall for three cycles.
      out_ready = 1'b0;
      drive(1'b1, 32'h104, C_ALU, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 5'd3);
      for (int i = 0; i < 3; i++) begin
         expect_ready(1'b0, '0, '0);
         tick();
         check_out(1'b1, 1'b0);
      end
      out_ready = 1'b1;
      expect_ready(1'b1, 32'h11, 32'h22);
      tick();
      check_out(1'b1, 1'b1);

      // Load to x5 followed by a consumer of x5: one bubble.
      drive(1'b1, 32'h108, C_LOAD, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 5'd5);
      expect_ready(1'b1, 32'h11, 32'h22);
      tick();
      check_out(1'b1, 1'b1);
      drive(1'b1, 32'h10C, C_ALU, 5'd5, 1'b1, 32'h55, 5'd6, 1'b0, 32'h66, 5'd9);
      expect_ready(1'b0, '0, '0);
      tick();
      check_out(1'b0, 1'b0);
      expect_ready(1'b1, 32'h55, 32'h66);
      tick();
      check_out(1'b1, 1'b1);

      // Load to x0 followed by a reader of x0: no bubble.
      drive(1'b1, 32'h110, C_LOAD, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 5'd0);
      expect_ready(1'b1, 32'h11, 32'h22);
      tick();
      check_out(1'b1, 1'b1);
      drive(1'b1, 32'h114, C_ALU, 5'd0, 1'b1, 32'h0, 5'd2, 1'b1, 32'h22, 5'd4);
      expect_ready(1'b1, 32'h0, 32'h22);
      tick();
      check_out(1'b1, 1'b1);

      // Flush coinciding with a load-use hazard.
      drive(1'b1, 32'h118, C_LOAD, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 5'd5);
      expect_ready(1'b1, 32'h11, 32'h22);
      tick();
      check_out(1'b1, 1'b1);
      flush = 1'b1;
      drive(1'b1, 32'h11C, C_ALU, 5'd5, 1'b1, 32'h55, 5'd2, 1'b1, 32'h22, 5'd6);
      expect_ready(1'b0, '0, '0);
      tick();
      check_out(1'b0, 1'b0);
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      check_out(1'b0, 1'b0);

      // Writeback to x7 while decode reads x7.
      wb_reg_write = 1'b1;  wb_addr = 5'd7;  wb_data = 32'hDEAD_BEEF;
      drive(1'b1, 32'h120, C_ALU, 5'd1, 1'b1, 32'h11, 5'd7, 1'b1, 32'h1, 5'd8);
`ifdef ID_WB_BYPASS_EN
      expect_ready(1'b1, 32'h11, 32'hDEAD_BEEF);
      tick();
      check_out(1'b1, 1'b1);
`else
      expect_ready(1'b0, '0, '0);
      tick();
      check_out(1'b0, 1'b0);
      wb_reg_write = 1'b0;
      rs2_data = 32'hDEAD_BEEF;
      expect_ready(1'b1, 32'h11, 32'hDEAD_BEEF);
      tick();
      check_out(1'b1, 1'b1);
`endif

      // Writeback targeting x0 never bypasses or stalls.
      wb_reg_write = 1'b1;  wb_addr = 5'd0;  wb_data = 32'hCAFE_F00D;
      drive(1'b1, 32'h124, C_ALU, 5'd1, 1'b1, 32'h11, 5'd0, 1'b1, 32'h0, 5'd8);
      expect_ready(1'b1, 32'h11, 32'h0);
      tick();
      check_out(1'b1, 1'b1);

`ifndef ID_WB_BYPASS_EN
      // Matching but unused source does not stall.
      wb_addr = 5'd7;  wb_data = 32'hDEAD_BEEF;
      drive(1'b1, 32'h128, C_ALU, 5'd1, 1'b1, 32'h11, 5'd7, 1'b0, 32'h77, 5'd8);
      expect_ready(1'b1, 32'h11, 32'h77);
      tick();
      check_out(1'b1, 1'b1);
`endif

      wb_reg_write = 1'b0;
      in_valid = 1'b0;
      tick();
      check_out(1'b0, 1'b0);
      chk("sb_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
